// File: rtl/exp_seq_pkg.sv
// exp_seq_pkg: shared states, register map and descriptor layout for the exp_mem_sequencer slice
package exp_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, WRITE} state_t;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DESC   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_TMO  = 3;
  localparam logic [1:0] DESC_BASE = 2'd0;
  localparam logic [1:0] DESC_EXP  = 2'd1;
  localparam logic [1:0] DESC_MOD  = 2'd2;
  localparam logic [1:0] DESC_RES  = 2'd3;
endpackage

// File: rtl/exp_seq_regs.sv
// exp_seq_regs: control register file (CTRL, DESC_ADDR, STATUS W1C, RESULT) and irq
// Ports: ctl_* Avalon slave side; busy/set_done/set_timeout/res_load/res_in from the FSM;
// start (accepted start pulse), desc_addr, result, irq back to the top.
module exp_seq_regs
  import exp_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ctl_address,
  input  logic              ctl_write,
  input  logic [DATA_W-1:0] ctl_writedata,
  input  logic              busy,
  input  logic              set_done,
  input  logic              set_timeout,
  input  logic              res_load,
  input  logic [DATA_W-1:0] res_in,
  output logic              start,
  output logic [ADDR_W-1:0] desc_addr,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] ctl_readdata,
  output logic              irq
);
  logic irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, tmo_q, tmo_d;
  logic [ADDR_W-1:0] desc_q, desc_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic wr_ctrl, start_cmd;
  logic [3:0] w1c, status;
  logic unused;
  always_comb begin
    wr_ctrl   = ctl_write && ctl_address == REG_CTRL;
    start_cmd = wr_ctrl && ctl_writedata[CTRL_START];
    w1c       = (ctl_write && ctl_address == REG_STATUS) ? ctl_writedata[3:0] : 4'b0;
    irq_en_d  = wr_ctrl ? ctl_writedata[CTRL_IRQ_EN] : irq_en_q;
    desc_d    = (ctl_write && ctl_address == REG_DESC) ? ctl_writedata[ADDR_W-1:0] : desc_q;
    // a timeout abandons the job, so any stale done is dropped with it
    done_d    = set_done | (done_q & ~w1c[ST_DONE] & ~set_timeout);
    err_d     = (start_cmd & busy) | (err_q & ~w1c[ST_ERR]);
    tmo_d     = set_timeout | (tmo_q & ~w1c[ST_TMO]);
    result_d  = res_load ? res_in : result_q;
    status           = 4'b0;
    status[ST_BUSY]  = busy;
    status[ST_DONE]  = done_q;
    status[ST_ERR]   = err_q;
    status[ST_TMO]   = tmo_q;
    ctl_readdata = ctl_address == REG_CTRL   ? DATA_W'({irq_en_q, 1'b0}) :
                   ctl_address == REG_DESC   ? DATA_W'(desc_q) :
                   ctl_address == REG_STATUS ? DATA_W'(status) : result_q;
  end
  always_ff @(posedge clk) begin
    irq_en_q <= !reset_n ? 1'b0 : irq_en_d;
    done_q   <= !reset_n ? 1'b0 : done_d;
    err_q    <= !reset_n ? 1'b0 : err_d;
    tmo_q    <= !reset_n ? 1'b0 : tmo_d;
    desc_q   <= !reset_n ? '0 : desc_d;
    result_q <= !reset_n ? '0 : result_d;
  end
  assign start     = start_cmd & ~busy;
  assign desc_addr = desc_q;
  assign result    = result_q;
  assign irq       = done_q & irq_en_q;
  assign unused    = ^ctl_writedata[DATA_W-1:ADDR_W];
endmodule

// File: rtl/exp_mem_sequencer.sv
// exp_mem_sequencer: fetches a base/exp/mod descriptor from RAM, runs the exponent engine, writes the result back
// Ports: ctl_* control registers; h_* host RAM pass-through; mem_* RAM port; eng_* exponent engine; irq.
// Optional macro EXP_SEQ_TIMEOUT_EN adds a TIMEOUT_CYCLES watchdog on the engine wait.
module exp_mem_sequencer
  import exp_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        ctl_address,
  input  logic              ctl_read,
  input  logic              ctl_write,
  input  logic [DATA_W-1:0] ctl_writedata,
  output logic [DATA_W-1:0] ctl_readdata,
  input  logic [ADDR_W-1:0] h_address,
  input  logic              h_chipselect,
  input  logic              h_write,
  input  logic [3:0]        h_byteenable,
  input  logic [DATA_W-1:0] h_writedata,
  output logic [DATA_W-1:0] h_readdata,
  output logic              h_waitrequest,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              mem_clken,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_base,
  output logic [DATA_W-1:0] eng_exp,
  output logic [DATA_W-1:0] eng_mod,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic              irq
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic fetch_q, fetch_d, eng_start_q, eng_start_d, h_rd_q, h_rd_d;
  logic [DATA_W-1:0] base_q, base_d, exp_q, exp_d, mod_q, mod_d;
  logic start, busy, own, set_done, set_timeout, res_load, tmo_hit, unused;
  logic [ADDR_W-1:0] desc_addr;
  logic [DATA_W-1:0] result;
  exp_seq_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_regs (
    .clk(clk), .reset_n(reset_n), .ctl_address(ctl_address), .ctl_write(ctl_write),
    .ctl_writedata(ctl_writedata), .busy(busy), .set_done(set_done), .set_timeout(set_timeout),
    .res_load(res_load), .res_in(eng_result), .start(start), .desc_addr(desc_addr),
    .result(result), .ctl_readdata(ctl_readdata), .irq(irq)
  );
`ifdef EXP_SEQ_TIMEOUT_EN
  logic [31:0] wcnt_q, wcnt_d;
  assign wcnt_d  = state_q == WAIT ? wcnt_q + 32'd1 : '0;
  assign tmo_hit = state_q == WAIT && wcnt_q == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) wcnt_q <= !reset_n ? '0 : wcnt_d;
  assign unused = ctl_read;
`else
  assign tmo_hit = 1'b0;
  assign unused  = ctl_read ^ (TIMEOUT_CYCLES != 0);
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_load    = 1'b0;
    set_done    = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        cnt_d   = '0;
      end
      FETCH: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == DESC_MOD) state_d = LAUNCH;
      end
      LAUNCH: state_d = WAIT;
      WAIT: if (eng_done) begin
        state_d  = WRITE;
        res_load = 1'b1;
      end else if (tmo_hit) begin
        state_d     = IDLE;
        set_timeout = 1'b1;
      end
      WRITE: begin
        state_d  = IDLE;
        set_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy = state_q != IDLE;
    own  = state_q inside {FETCH, LAUNCH, WRITE};
    // RAM q lags the address by one cycle, so capture uses the index presented last cycle
    fetch_d     = state_q == FETCH;
    idx_d       = cnt_q;
    base_d      = (fetch_q && idx_q == DESC_BASE) ? mem_readdata : base_q;
    exp_d       = (fetch_q && idx_q == DESC_EXP) ? mem_readdata : exp_q;
    mod_d       = (fetch_q && idx_q == DESC_MOD) ? mem_readdata : mod_q;
    eng_start_d = state_q == LAUNCH;
    h_rd_d      = h_chipselect & ~h_write & ~own;
    mem_address    = state_q == WRITE ? desc_addr + ADDR_W'(DESC_RES) :
                     state_q == FETCH ? desc_addr + ADDR_W'(cnt_q) : h_address;
    mem_chipselect = own ? (state_q == FETCH || state_q == WRITE) : h_chipselect;
    mem_write      = own ? state_q == WRITE : h_chipselect & h_write;
    mem_byteenable = own ? 4'hF : h_byteenable;
    mem_writedata  = own ? result : h_writedata;
    h_waitrequest  = own & h_chipselect;
    h_readdata     = h_rd_q ? mem_readdata : '0;
  end
  always_ff @(posedge clk) begin
    state_q     <= !reset_n ? IDLE : state_d;
    cnt_q       <= !reset_n ? '0 : cnt_d;
    idx_q       <= !reset_n ? '0 : idx_d;
    fetch_q     <= !reset_n ? 1'b0 : fetch_d;
    eng_start_q <= !reset_n ? 1'b0 : eng_start_d;
    h_rd_q      <= !reset_n ? 1'b0 : h_rd_d;
    base_q      <= !reset_n ? '0 : base_d;
    exp_q       <= !reset_n ? '0 : exp_d;
    mod_q       <= !reset_n ? '0 : mod_d;
  end
  assign mem_clken = 1'b1;
  assign eng_start = eng_start_q;
  assign eng_base  = base_q;
  assign eng_exp   = exp_q;
  assign eng_mod   = mod_q;
endmodule

// File: tb/tb_exp_mem_sequencer.sv
// tb_exp_mem_sequencer: directed and randomized jobs checked against a modexp reference model
module tb_exp_mem_sequencer;
  logic clk = 0, reset_n = 0;
  logic [1:0] ctl_address = 0;
  logic ctl_read = 0, ctl_write = 0;
  logic [31:0] ctl_writedata = 0, ctl_readdata;
  logic [9:0] h_address = 0;
  logic h_chipselect = 0, h_write = 0, h_waitrequest;
  logic [3:0] h_byteenable = 4'hF;
  logic [31:0] h_writedata = 0, h_readdata;
  logic [9:0] mem_address;
  logic mem_chipselect, mem_write, mem_clken;
  logic [3:0] mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic eng_start, eng_done = 0, irq;
  logic [31:0] eng_base, eng_exp, eng_mod, eng_result = 0;
  int total = 0, passes = 0;
  logic eng_en = 1, eng_force = 0, pend = 0;
  int lat = 0;
  logic [31:0] eb = 0, ee = 0, em = 0;
  logic [9:0] jd;
  logic [31:0] jb, je, jm, jr, dummy, v;
  logic [31:0] ram [1024];
  logic [31:0] ram_q = 0;

  exp_mem_sequencer dut (
    .clk(clk), .reset_n(reset_n), .ctl_address(ctl_address), .ctl_read(ctl_read),
    .ctl_write(ctl_write), .ctl_writedata(ctl_writedata), .ctl_readdata(ctl_readdata),
    .h_address(h_address), .h_chipselect(h_chipselect), .h_write(h_write),
    .h_byteenable(h_byteenable), .h_writedata(h_writedata), .h_readdata(h_readdata),
    .h_waitrequest(h_waitrequest), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_clken(mem_clken), .eng_start(eng_start),
    .eng_base(eng_base), .eng_exp(eng_exp), .eng_mod(eng_mod), .eng_done(eng_done),
    .eng_result(eng_result), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_chipselect && mem_clken) begin
      if (mem_write)
        for (int i = 0; i < 4; i++)
          if (mem_byteenable[i]) ram[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
      ram_q <= ram[mem_address];
    end
  assign mem_readdata = ram_q;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    logic [63:0] r, x, mm;
    if (m == 0) return 32'd0;
    mm = {32'd0, m};
    r = 64'd1 % mm;
    x = {32'd0, b} % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  // engine model: random latency, result from the operands it saw at eng_start
  initial begin
    forever begin
      @(posedge clk); #1;
      eng_done = 0;
      if (eng_force) begin
        eng_done = 1;
        eng_result = 32'hDEADBEEF;
      end else if (eng_start) begin
        pend = 1;
        lat = $urandom_range(2, 6);
        eb = eng_base; ee = eng_exp; em = eng_mod;
      end else if (pend && eng_en) begin
        if (lat == 0) begin
          eng_done = 1;
          eng_result = modexp(eb, ee, em);
          pend = 0;
        end else lat--;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ctl_wr(input logic [1:0] a, input logic [31:0] d);
    ctl_address = a; ctl_writedata = d; ctl_write = 1;
    tick();
    ctl_write = 0;
  endtask

  task automatic ctl_rd(input logic [1:0] a, output logic [31:0] d);
    ctl_address = a; #1;
    d = ctl_readdata;
  endtask

  task automatic host(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be, output logic [31:0] q);
    int n;
    h_address = a; h_write = w; h_writedata = d; h_byteenable = be; h_chipselect = 1; #1;
    n = 0;
    while (h_waitrequest && n < 50) begin tick(); n++; end
    chk("host_grant", 32'(h_waitrequest), 32'd0);
    tick();
    h_chipselect = 0; h_write = 0; #1;
    q = h_readdata;
  endtask

  task automatic prep(input logic [9:0] d, input logic [31:0] b, input logic [31:0] e, input logic [31:0] m, input logic clr);
    jd = d; jb = b; je = e; jm = m; jr = modexp(b, e, m);
    host(1, d, b, 4'hF, dummy);
    host(1, d + 10'd1, e, 4'hF, dummy);
    host(1, d + 10'd2, m, 4'hF, dummy);
    host(1, d + 10'd3, ~jr, 4'hF, dummy);
    if (clr) ctl_wr(2'd2, 32'hF);
    ctl_wr(2'd1, 32'(d));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    ctl_address = 2'd2; #1;
    while (ctl_readdata[0] && n < 300) begin tick(); n++; end
    chk("job_end_busy", 32'(ctl_readdata[0]), 32'd0);
  endtask

  task automatic job_check(input logic ie, input logic [31:0] st);
    logic [31:0] r;
    wait_idle();
    chk("eng_base", eb, jb);
    chk("eng_exp", ee, je);
    chk("eng_mod", em, jm);
    chk("ram_result", ram[jd + 10'd3], jr);
    ctl_rd(2'd3, r); chk("result_reg", r, jr);
    ctl_rd(2'd2, r); chk("status", r, st);
    chk("irq", 32'(irq), 32'(ie));
  endtask

  initial begin
    logic [31:0] r;
    logic ie;
    // reset state
    repeat (3) tick();
    chk("rst_mem_cs", 32'(mem_chipselect), 0);
    chk("rst_mem_wr", 32'(mem_write), 0);
    chk("rst_hwait", 32'(h_waitrequest), 0);
    chk("rst_eng_start", 32'(eng_start), 0);
    chk("rst_eng_base", eng_base, 0);
    chk("rst_irq", 32'(irq), 0);
    reset_n = 1;
    tick();
    ctl_rd(2'd0, r); chk("rst_ctrl", r, 0);
    ctl_rd(2'd1, r); chk("rst_desc", r, 0);
    ctl_rd(2'd2, r); chk("rst_status", r, 0);
    ctl_rd(2'd3, r); chk("rst_result", r, 0);
    // host pass-through with byte enables
    host(1, 10'h200, 32'hAABBCCDD, 4'hF, dummy);
    host(1, 10'h200, 32'h11223344, 4'b0101, dummy);
    host(0, 10'h200, 32'h0, 4'hF, r);
    chk("host_be_read", r, 32'hAA22CC44);
    // eng_done while idle is ignored
    eng_force = 1; tick(); tick(); eng_force = 0; tick();
    ctl_rd(2'd2, r); chk("spur_status", r, 0);
    ctl_rd(2'd3, r); chk("spur_result", r, 0);
    // worked example 3^5 mod 7 with irq enabled
    prep(10'h010, 32'd3, 32'd5, 32'd7, 1);
    ctl_wr(2'd0, 32'h3);
    job_check(1, 32'h2);
    chk("tp_ram13", ram[10'h013], 32'd5);
    ctl_wr(2'd2, 32'h2);
    chk("irq_cleared", 32'(irq), 0);
    ctl_rd(2'd2, r); chk("status_cleared", r, 0);
    // descriptor wrapping past the top of RAM
    prep(10'h3FE, $urandom, $urandom, $urandom | 32'd1, 1);
    ctl_wr(2'd0, 32'h1);
    job_check(0, 32'h2);
    chk("wrap_ram001", ram[10'h001], jr);
    // host read stalled by fetch, then served
    v = $urandom;
    host(1, 10'h020, v, 4'hF, dummy);
    prep(10'h040, $urandom, $urandom, $urandom | 32'd1, 1);
    ctl_wr(2'd0, 32'h1);
    h_address = 10'h020; h_write = 0; h_chipselect = 1; #1;
    begin
      int n;
      n = 0;
      while (h_waitrequest && n < 10) begin n++; tick(); end
      chk("stall_cycles", 32'(n), 32'd4);
    end
    tick();
    h_chipselect = 0; #1;
    chk("stall_read", h_readdata, v);
    job_check(0, 32'h2);
    // start while busy sets err and leaves the job alone
    prep(10'h060, $urandom, $urandom, $urandom | 32'd1, 1);
    ctl_wr(2'd0, 32'h1);
    tick();
    ctl_wr(2'd0, 32'h1);
    job_check(0, 32'h6);
    ctl_wr(2'd2, 32'h4);
    ctl_rd(2'd2, r); chk("err_w1c", r, 32'h2);
    // start with done still set is accepted, done stays set
    prep(10'h070, $urandom, $urandom, $urandom | 32'd1, 0);
    ctl_wr(2'd0, 32'h1);
    ctl_rd(2'd2, r); chk("busy_with_done", r, 32'h3);
    job_check(0, 32'h2);
    // start issued alongside an accepted host read
    prep(10'h080, $urandom, $urandom, $urandom | 32'd1, 1);
    v = $urandom;
    host(1, 10'h0F0, v, 4'hF, dummy);
    h_address = 10'h0F0; h_write = 0; h_chipselect = 1;
    ctl_address = 2'd0; ctl_writedata = 32'h1; ctl_write = 1;
    tick();
    ctl_write = 0; h_chipselect = 0; #1;
    chk("read_at_start", h_readdata, v);
    job_check(0, 32'h2);
    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      ie = 1'($urandom_range(0, 1));
      prep(10'($urandom_range(0, 1023)), $urandom, $urandom, $urandom | 32'd1, 1);
      ctl_wr(2'd0, 32'({ie, 1'b1}));
      job_check(ie, 32'h2);
    end
    // reset during WAIT aborts without write-back
    prep(10'h100, $urandom, $urandom, $urandom | 32'd1, 1);
    eng_en = 0;
    ctl_wr(2'd0, 32'h3);
    repeat (8) tick();
    ctl_rd(2'd2, r); chk("wait_busy", r, 32'h1);
    reset_n = 0; tick(); reset_n = 1; #1;
    ctl_rd(2'd2, r); chk("abort_status", r, 0);
    ctl_rd(2'd0, r); chk("abort_ctrl", r, 0);
    chk("abort_eng_mod", eng_mod, 0);
    eng_en = 1;
    repeat (12) tick();
    ctl_rd(2'd2, r); chk("late_done_status", r, 0);
    ctl_rd(2'd3, r); chk("late_done_result", r, 0);
    chk("abort_no_wb", ram[10'h103], ~jr);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
